// File: rtl/exe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exe_pkg : ALU command codes, status indices, shift types and FSM states.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package exe_pkg;

  localparam logic [3:0] c_CMD_MOV = 4'b0001;
  localparam logic [3:0] c_CMD_MVN = 4'b1001;
  localparam logic [3:0] c_CMD_ADD = 4'b0010;
  localparam logic [3:0] c_CMD_ADC = 4'b0011;
  localparam logic [3:0] c_CMD_SUB = 4'b0100;
  localparam logic [3:0] c_CMD_SBC = 4'b0101;
  localparam logic [3:0] c_CMD_AND = 4'b0110;
  localparam logic [3:0] c_CMD_ORR = 4'b0111;
  localparam logic [3:0] c_CMD_EOR = 4'b1000;

  localparam int c_ST_N = 3;
  localparam int c_ST_Z = 2;
  localparam int c_ST_C = 1;
  localparam int c_ST_V = 0;

  localparam logic [1:0] c_SHIFT_LSL = 2'b00;
  localparam logic [1:0] c_SHIFT_LSR = 2'b01;
  localparam logic [1:0] c_SHIFT_ASR = 2'b10;
  localparam logic [1:0] c_SHIFT_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_WAIT = 2'd2
  } exe_state_e;

endpackage
`default_nettype wire

// File: rtl/mul_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_iter : radix-2 shift-add multiplier, one step per cycle, DATA_W steps.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] acc,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_acc_next;

  // product already includes the step taken this cycle, so the final value is
  // visible in the same cycle that done is high.
  always_comb begin
    w_acc_next = r_acc;
    if (busy && r_mplier[0]) begin
      w_acc_next = r_acc + r_mcand;
    end
  end

  assign busy    = (r_cnt != '0);
  assign done    = (r_cnt == CNT_W'(1));
  assign product = w_acc_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (start) begin
      r_cnt    <= CNT_W'(DATA_W);
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= acc;
    end else if (busy) begin
      r_cnt    <= r_cnt - CNT_W'(1);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_acc_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/exe_stage_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exe_stage_mc : execute stage with forwarding, ALU, iterative MUL and a     |
// | registered valid/ready EX/MEM slot. Optional macro EXE_MLA_EN adds MLA.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int  DATA_W  = 32,
  parameter int  NUM_FWD = 2,
  localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      validIn,
  output logic                      readyOut,
  input  logic                      flushIn,
  input  logic                      mulIn,
  input  logic                      mlaIn,
  input  logic                      MEM_R_ENIn,
  input  logic                      MEM_W_ENIn,
  input  logic                      IIn,
  input  logic [3:0]                EXE_CMDIn,
  input  logic [3:0]                statusIn,
  input  logic [11:0]               shiftOperandIn,
  input  logic [23:0]               Imm24In,
  input  logic [DATA_W-1:0]         PCIn,
  input  logic [DATA_W-1:0]         Val_RnIn,
  input  logic [DATA_W-1:0]         Val_RmIn,
  input  logic [DATA_W-1:0]         Val_RaIn,
  input  logic [NUM_FWD*DATA_W-1:0] fwdValuesIn,
  input  logic [SEL_W-1:0]          selSrc1In,
  input  logic [SEL_W-1:0]          selSrc2In,
  input  logic                      readyIn,
  output logic                      validOut,
  output logic [DATA_W-1:0]         ALU_ResOut,
  output logic [3:0]                statusOut,
  output logic [DATA_W-1:0]         branchAddressOut
);

  function automatic logic [DATA_W-1:0] f_ror(input logic [DATA_W-1:0] v, input logic [5:0] n);
    logic [2*DATA_W-1:0] d;
    d = {v, v} >> (n % DATA_W);
    return d[DATA_W-1:0];
  endfunction

  exe_state_e        r_state;
  exe_state_e        w_state_next;
  logic              r_valid;
  logic [DATA_W-1:0] r_res;
  logic [3:0]        r_status;
  logic [DATA_W-1:0] r_branch;
  logic              r_mul_c;
  logic              r_mul_v;

  logic [DATA_W-1:0] w_src1;
  logic [DATA_W-1:0] w_src2;
  logic [DATA_W-1:0] w_val2;
  logic [4:0]        w_shamt;
  logic [DATA_W-1:0] w_add_b;
  logic              w_cin;
  logic [DATA_W:0]   w_sum;
  logic              w_add_v;
  logic [DATA_W-1:0] w_alu_res;
  logic [3:0]        w_alu_flags;
  logic              w_upd_nz;
  logic              w_upd_cv;
  logic [25:0]       w_off26;
  logic [DATA_W-1:0] w_branch;
  logic              w_slot_free;
  logic              w_slot_drain;
  logic              w_accept;
  logic              w_mul_start;
  logic              w_mul_load;
  logic              w_mul_busy;
  logic              w_mul_done;
  logic              w_mul_last;
  logic [DATA_W-1:0] w_mul_acc;
  logic [DATA_W-1:0] w_mul_product;
  logic [3:0]        w_mul_flags;

  // Select codes above NUM_FWD fall through to the register-file value.
  always_comb begin
    w_src1 = Val_RnIn;
    w_src2 = Val_RmIn;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (selSrc1In == SEL_W'(k + 1)) w_src1 = fwdValuesIn[k*DATA_W +: DATA_W];
      if (selSrc2In == SEL_W'(k + 1)) w_src2 = fwdValuesIn[k*DATA_W +: DATA_W];
    end
  end

  assign w_shamt = shiftOperandIn[11:7];

  always_comb begin
    w_val2 = w_src2;
    if (MEM_R_ENIn || MEM_W_ENIn) begin
      w_val2 = DATA_W'(shiftOperandIn);
    end else if (IIn) begin
      w_val2 = f_ror(DATA_W'(shiftOperandIn[7:0]), {1'b0, shiftOperandIn[11:8], 1'b0});
    end else begin
      case (shiftOperandIn[6:5])
        c_SHIFT_LSL: w_val2 = w_src2 << w_shamt;
        c_SHIFT_LSR: w_val2 = w_src2 >> w_shamt;
        c_SHIFT_ASR: w_val2 = $signed(w_src2) >>> w_shamt;
        c_SHIFT_ROR: w_val2 = f_ror(w_src2, {1'b0, w_shamt});
        default:     w_val2 = w_src2;
      endcase
    end
  end

  // Subtraction is a + ~b + 1 so C reads as "no borrow".
  always_comb begin
    w_add_b = w_val2;
    w_cin   = 1'b0;
    case (EXE_CMDIn)
      c_CMD_ADC: w_cin = statusIn[c_ST_C];
      c_CMD_SUB: begin w_add_b = ~w_val2; w_cin = 1'b1;              end
      c_CMD_SBC: begin w_add_b = ~w_val2; w_cin = statusIn[c_ST_C];  end
      default:   w_cin = 1'b0;
    endcase
    w_sum   = {1'b0, w_src1} + {1'b0, w_add_b} + {{DATA_W{1'b0}}, w_cin};
    w_add_v = (w_src1[DATA_W-1] == w_add_b[DATA_W-1]) && (w_sum[DATA_W-1] != w_src1[DATA_W-1]);
  end

  always_comb begin
    w_alu_res = '0;
    w_upd_nz  = 1'b1;
    w_upd_cv  = 1'b0;
    case (EXE_CMDIn)
      c_CMD_MOV: w_alu_res = w_val2;
      c_CMD_MVN: w_alu_res = ~w_val2;
      c_CMD_AND: w_alu_res = w_src1 & w_val2;
      c_CMD_ORR: w_alu_res = w_src1 | w_val2;
      c_CMD_EOR: w_alu_res = w_src1 ^ w_val2;
      c_CMD_ADD, c_CMD_ADC, c_CMD_SUB, c_CMD_SBC: begin
        w_alu_res = w_sum[DATA_W-1:0];
        w_upd_cv  = 1'b1;
      end
      default: w_upd_nz = 1'b0;
    endcase
    w_alu_flags = statusIn;
    if (w_upd_nz) begin
      w_alu_flags[c_ST_N] = w_alu_res[DATA_W-1];
      w_alu_flags[c_ST_Z] = (w_alu_res == '0);
    end
    if (w_upd_cv) begin
      w_alu_flags[c_ST_C] = w_sum[DATA_W];
      w_alu_flags[c_ST_V] = w_add_v;
    end
  end

  assign w_off26  = {Imm24In, 2'b00};
  assign w_branch = PCIn + DATA_W'($signed(w_off26));

  assign w_slot_free  = !r_valid || readyIn;
  assign w_slot_drain = r_valid && readyIn;
  assign readyOut     = (r_state == IDLE) && w_slot_free;
  assign w_accept     = validIn && readyOut && !flushIn;
  assign w_mul_start  = w_accept && mulIn;
  assign w_mul_last   = w_mul_busy && w_mul_done;

`ifdef EXE_MLA_EN
  assign w_mul_acc = mlaIn ? Val_RaIn : '0;
`else
  logic w_unused_mla;
  assign w_mul_acc    = '0;
  assign w_unused_mla = ^{mlaIn, Val_RaIn};
`endif

  mul_iter #(
    .DATA_W (DATA_W)
  ) u_mul_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .a       (w_src1),
    .b       (w_src2),
    .acc     (w_mul_acc),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_mul_product)
  );

  always_comb begin
    w_mul_flags         = 4'b0000;
    w_mul_flags[c_ST_N] = w_mul_product[DATA_W-1];
    w_mul_flags[c_ST_Z] = (w_mul_product == '0);
    w_mul_flags[c_ST_C] = r_mul_c;
    w_mul_flags[c_ST_V] = r_mul_v;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_mul_load   = 1'b0;
    if (flushIn) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_mul_start) w_state_next = MUL_BUSY;
        MUL_BUSY: begin
          if (w_mul_last) begin
            if (w_slot_free) begin
              w_mul_load   = 1'b1;
              w_state_next = IDLE;
            end else begin
              w_state_next = MUL_WAIT;
            end
          end
        end
        MUL_WAIT: begin
          if (w_slot_free) begin
            w_mul_load   = 1'b1;
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // A drain and a new load in the same cycle leave r_valid set: no bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_res    <= '0;
      r_status <= 4'b0000;
      r_branch <= '0;
      r_mul_c  <= 1'b0;
      r_mul_v  <= 1'b0;
    end else if (flushIn) begin
      r_valid <= 1'b0;
    end else begin
      if (w_slot_drain) r_valid <= 1'b0;
      if (w_accept) r_branch <= w_branch;
      if (w_mul_start) begin
        r_mul_c <= statusIn[c_ST_C];
        r_mul_v <= statusIn[c_ST_V];
      end
      if (w_accept && !mulIn) begin
        r_valid  <= 1'b1;
        r_res    <= w_alu_res;
        r_status <= w_alu_flags;
      end else if (w_mul_load) begin
        r_valid  <= 1'b1;
        r_res    <= w_mul_product;
        r_status <= w_mul_flags;
      end
    end
  end

  assign validOut         = r_valid;
  assign ALU_ResOut       = r_res;
  assign statusOut        = r_status;
  assign branchAddressOut = r_branch;

endmodule
`default_nettype wire

// File: tb/tb_exe_stage_mc.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_exe_stage_mc : directed and random stimulus against a behavioural model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_exe_stage_mc;

  localparam int DATA_W  = 32;
  localparam int NUM_FWD = 2;
  localparam longint MAXI = 2147483647;
  localparam longint MINI = -MAXI - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        validIn = 1'b0, flushIn = 1'b0, mulIn = 1'b0, mlaIn = 1'b0;
  logic        MEM_R_ENIn = 1'b0, MEM_W_ENIn = 1'b0, IIn = 1'b0, readyIn = 1'b1;
  logic [3:0]  EXE_CMDIn = '0, statusIn = '0;
  logic [11:0] shiftOperandIn = '0;
  logic [23:0] Imm24In = '0;
  logic [31:0] PCIn = '0, Val_RnIn = '0, Val_RmIn = '0, Val_RaIn = '0;
  logic [63:0] fwdValuesIn = '0;
  logic [1:0]  selSrc1In = '0, selSrc2In = '0;
  logic        readyOut, validOut;
  logic [31:0] ALU_ResOut, branchAddressOut;
  logic [3:0]  statusOut;

  exe_stage_mc #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) dut (
    .clk(clk), .rst(rst), .validIn(validIn), .readyOut(readyOut), .flushIn(flushIn),
    .mulIn(mulIn), .mlaIn(mlaIn), .MEM_R_ENIn(MEM_R_ENIn), .MEM_W_ENIn(MEM_W_ENIn),
    .IIn(IIn), .EXE_CMDIn(EXE_CMDIn), .statusIn(statusIn), .shiftOperandIn(shiftOperandIn),
    .Imm24In(Imm24In), .PCIn(PCIn), .Val_RnIn(Val_RnIn), .Val_RmIn(Val_RmIn),
    .Val_RaIn(Val_RaIn), .fwdValuesIn(fwdValuesIn), .selSrc1In(selSrc1In),
    .selSrc2In(selSrc2In), .readyIn(readyIn), .validOut(validOut), .ALU_ResOut(ALU_ResOut),
    .statusOut(statusOut), .branchAddressOut(branchAddressOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, mul, mla, mr, mw, i;
    logic [3:0]  cmd, st;
    logic [11:0] so;
    logic [23:0] imm;
    logic [31:0] pc, rn, rm, ra, f0, f1;
    logic [1:0]  s1, s2;
  } ins_t;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: slot contents and remaining MUL cycles
  logic        m_valid = 1'b0;
  logic [31:0] m_res = '0, m_br = '0, m_mul_res = '0;
  logic [3:0]  m_flags = '0, m_mul_flags = '0;
  int          m_mul_left = 0;
  logic        m_wait = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic ins_t blank();
    ins_t s;
    s.v = 0; s.mul = 0; s.mla = 0; s.mr = 0; s.mw = 0; s.i = 0;
    s.cmd = 0; s.st = 0; s.so = 0; s.imm = 0;
    s.pc = 0; s.rn = 0; s.rm = 0; s.ra = 0; s.f0 = 0; s.f1 = 0; s.s1 = 0; s.s2 = 0;
    return s;
  endfunction

  function automatic logic [31:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 3));
    return $urandom;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t s;
    s.v = ($urandom_range(0, 9) < 7); s.mul = ($urandom_range(0, 9) == 0);
    s.mla = 1'($urandom); s.mr = ($urandom_range(0, 7) == 0); s.mw = ($urandom_range(0, 7) == 0);
    s.i = 1'($urandom); s.cmd = 4'($urandom); s.st = 4'($urandom);
    s.so = 12'($urandom); s.imm = 24'($urandom); s.pc = $urandom & 32'hFFFF_FFFC;
    s.rn = rnd_val(); s.rm = rnd_val(); s.ra = rnd_val(); s.f0 = rnd_val(); s.f1 = rnd_val();
    s.s1 = 2'($urandom); s.s2 = 2'($urandom);
    return s;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v, input ins_t s);
    if (sel == 2'd1) return s.f0;
    if (sel == 2'd2) return s.f1;
    return reg_v;
  endfunction

  function automatic logic [31:0] ref_val2(input ins_t s, input logic [31:0] rm);
    logic [63:0] d;
    int amt;
    if (s.mr || s.mw) return {20'd0, s.so};
    if (s.i) begin
      d = {24'd0, s.so[7:0], 24'd0, s.so[7:0]} >> (2 * int'(s.so[11:8]));
      return d[31:0];
    end
    amt = int'(s.so[11:7]);
    case (s.so[6:5])
      2'd0: return rm << amt;
      2'd1: return rm >> amt;
      2'd2: return $signed(rm) >>> amt;
      default: begin d = {rm, rm} >> amt; return d[31:0]; end
    endcase
  endfunction

  task automatic ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] st, output logic [31:0] res, output logic [3:0] fl);
    longint u, sg;
    int ci;
    bit nz, cv;
    res = '0; fl = st; nz = 1; cv = 0; u = 0; sg = 0;
    ci = int'(st[1]);
    case (cmd)
      4'h1: res = b;
      4'h9: res = ~b;
      4'h6: res = a & b;
      4'h7: res = a | b;
      4'h8: res = a ^ b;
      4'h2, 4'h3: begin
        if (cmd == 4'h2) ci = 0;
        u  = longint'(a) + longint'(b) + ci;
        sg = longint'($signed(a)) + longint'($signed(b)) + ci;
        res = u[31:0]; cv = 1; fl[1] = u[32];
      end
      4'h4, 4'h5: begin
        if (cmd == 4'h4) ci = 1;
        u  = longint'(a) - longint'(b) - (1 - ci);
        sg = longint'($signed(a)) - longint'($signed(b)) - (1 - ci);
        res = u[31:0]; cv = 1; fl[1] = (u >= 0);
      end
      default: nz = 0;
    endcase
    if (nz) begin fl[3] = res[31]; fl[2] = (res == 0); end
    if (cv) fl[0] = (sg > MAXI) || (sg < MINI);
  endtask

  function automatic logic [31:0] br_target(input ins_t s);
    logic signed [25:0] o;
    o = {s.imm, 2'b00};
    return s.pc + 32'(o);
  endfunction

  function automatic logic model_ready(input logic rdy);
    return (m_mul_left == 0) && !m_wait && (!m_valid || rdy);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_res = 0; m_flags = 0; m_br = 0; m_mul_left = 0; m_wait = 0;
  endtask

  // Drives one cycle starting just after a rising edge and checks just after the next.
  task automatic apply(input ins_t s, input logic rdy, input logic fl);
    logic acc, free;
    logic [31:0] a, b, r;
    logic [3:0]  f;
    validIn = s.v; mulIn = s.mul; mlaIn = s.mla; MEM_R_ENIn = s.mr; MEM_W_ENIn = s.mw;
    IIn = s.i; EXE_CMDIn = s.cmd; statusIn = s.st; shiftOperandIn = s.so; Imm24In = s.imm;
    PCIn = s.pc; Val_RnIn = s.rn; Val_RmIn = s.rm; Val_RaIn = s.ra;
    fwdValuesIn = {s.f1, s.f0}; selSrc1In = s.s1; selSrc2In = s.s2;
    readyIn = rdy; flushIn = fl;
    #1;
    chk("readyOut", {63'd0, readyOut}, {63'd0, model_ready(rdy)});
    acc  = s.v && model_ready(rdy) && !fl;
    free = !m_valid || rdy;
    a = pick(s.s1, s.rn, s);
    b = pick(s.s2, s.rm, s);
    @(posedge clk);
    #1;
    if (fl) begin
      m_valid = 0; m_mul_left = 0; m_wait = 0;
    end else begin
      if (m_valid && rdy) m_valid = 0;
      if (acc) begin
        m_br = br_target(s);
        if (!s.mul) begin
          ref_alu(s.cmd, a, ref_val2(s, b), s.st, r, f);
          m_valid = 1; m_res = r; m_flags = f;
        end else begin
          r = a * b;
`ifdef EXE_MLA_EN
          if (s.mla) r = r + s.ra;
`endif
          m_mul_left  = DATA_W;
          m_mul_res   = r;
          m_mul_flags = {r[31], (r == 0), s.st[1], s.st[0]};
        end
      end else if (m_mul_left > 0) begin
        m_mul_left--;
        if (m_mul_left == 0) begin
          if (free) begin m_valid = 1; m_res = m_mul_res; m_flags = m_mul_flags; end
          else m_wait = 1;
        end
      end else if (m_wait && free) begin
        m_valid = 1; m_res = m_mul_res; m_flags = m_mul_flags; m_wait = 0;
      end
    end
    chk("validOut", {63'd0, validOut}, {63'd0, m_valid});
    if (m_valid) begin
      chk("ALU_ResOut", {32'd0, ALU_ResOut}, {32'd0, m_res});
      chk("statusOut", {60'd0, statusOut}, {60'd0, m_flags});
    end
    chk("branchAddressOut", {32'd0, branchAddressOut}, {32'd0, m_br});
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_validOut"}, {63'd0, validOut}, 64'd0);
    chk({tag, "_ALU_ResOut"}, {32'd0, ALU_ResOut}, 64'd0);
    chk({tag, "_statusOut"}, {60'd0, statusOut}, 64'd0);
    chk({tag, "_branchAddressOut"}, {32'd0, branchAddressOut}, 64'd0);
  endtask

  initial begin
    ins_t s, idle;
    int   lat;
    idle = blank();

    @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    chk("reset_readyOut", {63'd0, readyOut}, 64'd1);
    rst = 1'b1;

    // ADD 5 + 7
    s = blank(); s.v = 1; s.cmd = 4'b0010; s.rn = 5; s.rm = 7; s.pc = 32'h100; s.imm = 24'h000004;
    apply(s, 1, 0);
    chk("t1_res", {32'd0, ALU_ResOut}, 64'd12);
    chk("t1_status", {60'd0, statusOut}, 64'd0);
    chk("t1_branch", {32'd0, branchAddressOut}, 64'h110);

    // SUB 3 - 3 with Rn taken from forwarding source 0
    s = blank(); s.v = 1; s.cmd = 4'b0100; s.rn = 99; s.f0 = 3; s.s1 = 2'd1; s.rm = 3;
    apply(s, 1, 0);
    chk("t2_res", {32'd0, ALU_ResOut}, 64'd0);
    chk("t2_status", {60'd0, statusOut}, 64'b0110);

    // MUL latency
    apply(idle, 1, 0);
    s = blank(); s.v = 1; s.mul = 1; s.rn = 32'h0000FFFF; s.rm = 32'h00010001;
    apply(s, 1, 0);
    lat = 1;
    while (!validOut && lat < 100) begin
      apply(idle, 1, 0);
      lat++;
    end
    chk("t3_latency", 64'(lat), 64'd33);
    chk("t3_res", {32'd0, ALU_ResOut}, 64'hFFFFFFFF);
    chk("t3_N", {63'd0, statusOut[3]}, 64'd1);

    // MLA 6*7 + 100
    s = blank(); s.v = 1; s.mul = 1; s.mla = 1; s.rn = 6; s.rm = 7; s.ra = 100;
    apply(s, 1, 0);
    for (int k = 0; k < 40 && !validOut; k++) apply(idle, 1, 0);
`ifdef EXE_MLA_EN
    chk("t4_mla", {32'd0, ALU_ResOut}, 64'd142);
`else
    chk("t4_mla", {32'd0, ALU_ResOut}, 64'd42);
`endif

    // stall, hold, then drain-and-accept together
    s = blank(); s.v = 1; s.cmd = 4'b0111; s.rn = 32'hF0; s.rm = 32'h0F;
    apply(s, 1, 0);
    s = blank(); s.v = 1; s.cmd = 4'b0001; s.i = 1; s.so = 12'h1FF;
    for (int k = 0; k < 3; k++) begin
      apply(s, 0, 0);
      chk("t5_hold", {32'd0, ALU_ResOut}, 64'hFF);
      chk("t5_ready_low", {63'd0, readyOut}, 64'd0);
    end
    apply(s, 1, 0);
    chk("t5_reload", {32'd0, ALU_ResOut}, 64'hC000003F);
    chk("t5_valid", {63'd0, validOut}, 64'd1);

    // flush during MUL
    s = blank(); s.v = 1; s.mul = 1; s.rn = 123; s.rm = 456;
    apply(s, 1, 0);
    for (int k = 0; k < 9; k++) apply(idle, 1, 0);
    apply(idle, 1, 1);
    chk("t6_valid", {63'd0, validOut}, 64'd0);
    chk("t6_ready", {63'd0, readyOut}, 64'd1);
    for (int k = 0; k < 40; k++) apply(idle, 1, 0);

    // reset during MUL
    s = blank(); s.v = 1; s.mul = 1; s.rn = 77; s.rm = 88; s.pc = 32'h2000;
    apply(s, 1, 0);
    for (int k = 0; k < 5; k++) apply(idle, 1, 0);
    #2 rst = 1'b0;
    #1;
    chk_zero_outputs("rst_mid_mul");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int n = 0; n < 2500; n++) begin
      apply(rnd_ins(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
